// File: rtl/apb_master_if.sv
// -----------------------------------------------------------------------------
// apb_master_if
// Bundles the host request/response handshake and the APB bus of apb_master.
//   host side : req_valid, req_ready, req_write, req_addr, req_wdata,
//               rsp_valid, rsp_rdata, rsp_err, busy
//   APB side  : PADDR, PWDATA, PWRITE, PSELx, PENABLE, PRDATA, PREADY
// modport master : the apb_master view (drives APB + response, reads request)
// modport slave  : the surroundings (host + APB responder)
// -----------------------------------------------------------------------------
interface apb_master_if #(
   parameter int ADDRESSWIDTH = 4,
   parameter int DATAWIDTH    = 24
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [ADDRESSWIDTH-1:0] req_addr;
   logic [DATAWIDTH-1:0]    req_wdata;
   logic                    rsp_valid;
   logic [DATAWIDTH-1:0]    rsp_rdata;
   logic                    rsp_err;
   logic                    busy;
   logic [ADDRESSWIDTH-1:0] PADDR;
   logic [DATAWIDTH-1:0]    PWDATA;
   logic                    PWRITE;
   logic                    PSELx;
   logic                    PENABLE;
   logic [DATAWIDTH-1:0]    PRDATA;
   logic                    PREADY;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
             PADDR, PWDATA, PWRITE, PSELx, PENABLE
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
             PADDR, PWDATA, PWRITE, PSELx, PENABLE
   );
endinterface

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
// Single-outstanding APB requester for the SAE controller register file.
// A host request (valid/ready) is turned into an APB SETUP + ACCESS sequence;
// PREADY wait states are honoured, a stuck access is aborted after TIMEOUT
// cycles, and the result comes back as a one-cycle rsp_valid pulse.
// Ports:
//   PCLK     : clock
//   PRESETn  : asynchronous active-low reset
//   bus      : apb_master_if.master (host request/response + APB signals)
// All bus outputs are registered except req_ready, which is combinational so
// a new request can be taken in the completing ACCESS cycle (back-to-back).
// -----------------------------------------------------------------------------
module apb_master #(
   parameter int ADDRESSWIDTH    = 4,
   parameter int DATAWIDTH       = 24,
   parameter int TIMEOUT         = 16,
   parameter int RD_SAMPLE_DELAY = 1
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   apb_master_if.master  bus
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]        TO_LAST   = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [DATAWIDTH-1:0]    ZERO_DATA = {DATAWIDTH{1'b0}};
   localparam logic [ADDRESSWIDTH-1:0] ZERO_ADDR = {ADDRESSWIDTH{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RDWAIT = 2'd3
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             timeout_s;
   logic             complete_s;
   logic             req_ready_s;
   logic             accept_s;

   // Timeout detection: last allowed ACCESS cycle and the responder is still stalling.
   always_comb begin
      timeout_s = 1'b0;
      if ((TIMEOUT > 0) && (state_r == ST_ACCESS) && !bus.PREADY && (cnt_r == TO_LAST)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
      complete_s = (state_r == ST_ACCESS) && (bus.PREADY || timeout_s);
   end

   // Ready: always in IDLE; in a completing ACCESS unless a delayed read still owes RDWAIT.
   always_comb begin
      req_ready_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            req_ready_s = 1'b1;
         end
         ST_ACCESS: begin
            if (complete_s && (bus.PWRITE || (RD_SAMPLE_DELAY == 0))) begin
               req_ready_s = 1'b1;
            end else begin
               req_ready_s = 1'b0;
            end
         end
         default: begin
            req_ready_s = 1'b0;
         end
      endcase
      accept_s = bus.req_valid && req_ready_s;
   end

   assign bus.req_ready = req_ready_s;

   // Transfer FSM with registered APB and response outputs.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_r       <= ST_IDLE;
         cnt_r         <= {CNT_W{1'b0}};
         bus.PADDR     <= ZERO_ADDR;
         bus.PWDATA    <= ZERO_DATA;
         bus.PWRITE    <= 1'b0;
         bus.PSELx     <= 1'b0;
         bus.PENABLE   <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= ZERO_DATA;
         bus.rsp_err   <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  bus.PWRITE  <= bus.req_write;
                  bus.PADDR   <= bus.req_addr;
                  bus.PWDATA  <= bus.req_wdata;
                  bus.PSELx   <= 1'b1;
                  bus.PENABLE <= 1'b0;
                  bus.busy    <= 1'b1;
                  state_r     <= ST_SETUP;
               end else begin
                  bus.PSELx   <= 1'b0;
                  bus.PENABLE <= 1'b0;
                  bus.busy    <= 1'b0;
               end
            end
            ST_SETUP: begin
               cnt_r       <= {CNT_W{1'b0}};
               bus.PSELx   <= 1'b1;
               bus.PENABLE <= 1'b1;
               bus.busy    <= 1'b1;
               state_r     <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (bus.PREADY && !bus.PWRITE && (RD_SAMPLE_DELAY != 0)) begin
                  // Responder registers PRDATA: release the bus, sample next cycle.
                  bus.PSELx   <= 1'b0;
                  bus.PENABLE <= 1'b0;
                  bus.busy    <= 1'b1;
                  state_r     <= ST_RDWAIT;
               end else if (complete_s) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= timeout_s;
                  bus.rsp_rdata <= (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : ZERO_DATA;
                  if (accept_s) begin
                     // Back-to-back: PSELx stays high, PENABLE drops for the new SETUP.
                     bus.PWRITE  <= bus.req_write;
                     bus.PADDR   <= bus.req_addr;
                     bus.PWDATA  <= bus.req_wdata;
                     bus.PSELx   <= 1'b1;
                     bus.PENABLE <= 1'b0;
                     bus.busy    <= 1'b1;
                     state_r     <= ST_SETUP;
                  end else begin
                     bus.PSELx   <= 1'b0;
                     bus.PENABLE <= 1'b0;
                     bus.busy    <= 1'b0;
                     state_r     <= ST_IDLE;
                  end
               end else begin
                  cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_RDWAIT: begin
               bus.rsp_valid <= 1'b1;
               bus.rsp_err   <= 1'b0;
               bus.rsp_rdata <= bus.PRDATA;
               bus.PSELx     <= 1'b0;
               bus.PENABLE   <= 1'b0;
               bus.busy      <= 1'b0;
               state_r       <= ST_IDLE;
            end
            default: begin
               bus.PSELx   <= 1'b0;
               bus.PENABLE <= 1'b0;
               bus.busy    <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_master
// Self-checking bench for apb_master (TIMEOUT=8, RD_SAMPLE_DELAY=1).
// The bench plays both host and APB responder. Expected behaviour of each
// transfer (number of ACCESS cycles, error flag, returned data, RDWAIT) comes
// from a small transaction-level model; cycle-by-cycle bus checks follow it.
// -----------------------------------------------------------------------------
module tb_apb_master;

   localparam int AW  = 4;
   localparam int DW  = 24;
   localparam int TO  = 8;
   localparam int RSD = 1;

   logic PCLK    = 1'b0;
   logic PRESETn = 1'b0;

   apb_master_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) bus_if ();

   apb_master #(
      .ADDRESSWIDTH   (AW),
      .DATAWIDTH      (DW),
      .TIMEOUT        (TO),
      .RD_SAMPLE_DELAY(RSD)
   ) dut (
      .PCLK   (PCLK),
      .PRESETn(PRESETn),
      .bus    (bus_if)
   );

   always #5 PCLK = ~PCLK;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      int          n_access;
      bit          err;
      bit          rdwait;
      logic [23:0] rdata;
   } exp_t;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transaction-level expectation: a responder stalling `waits` cycles.
   function automatic exp_t model(input bit wr, input int waits, input logic [23:0] rd);
      exp_t e;
      if ((TO > 0) && (waits >= TO)) begin
         e.n_access = TO;
         e.err      = 1'b1;
         e.rdwait   = 1'b0;
         e.rdata    = 24'h0;
      end else begin
         e.n_access = waits + 1;
         e.err      = 1'b0;
         e.rdwait   = !wr && (RSD != 0);
         e.rdata    = wr ? 24'h0 : rd;
      end
      return e;
   endfunction

   // One complete transfer starting and ending at a negedge with the DUT idle.
   task automatic xfer(input bit wr, input logic [3:0] a, input logic [23:0] d,
                       input int waits, input logic [23:0] rd, input bit late_ready);
      exp_t e;
      bit   last;
      e = model(wr, waits, rd);
      chk("idle_req_ready", bus_if.req_ready, 1);
      bus_if.req_valid = 1'b1;
      bus_if.req_write = wr;
      bus_if.req_addr  = a;
      bus_if.req_wdata = d;
      bus_if.PREADY    = 1'b0;
      @(negedge PCLK);
      // changes while not ready must be ignored
      bus_if.req_valid = 1'b0;
      bus_if.req_write = 1'($urandom_range(0, 1));
      bus_if.req_addr  = 4'($urandom_range(0, 15));
      bus_if.req_wdata = 24'($urandom);
      chk("setup_psel",   bus_if.PSELx, 1);
      chk("setup_penable", bus_if.PENABLE, 0);
      chk("setup_paddr",  bus_if.PADDR, a);
      chk("setup_pwrite", bus_if.PWRITE, wr);
      chk("setup_pwdata", bus_if.PWDATA, d);
      chk("setup_busy",   bus_if.busy, 1);
      chk("setup_ready",  bus_if.req_ready, 0);
      for (int k = 0; k < e.n_access; k++) begin
         @(negedge PCLK);
         chk("acc_psel",    bus_if.PSELx, 1);
         chk("acc_penable", bus_if.PENABLE, 1);
         chk("acc_paddr",   bus_if.PADDR, a);
         chk("acc_pwdata",  bus_if.PWDATA, d);
         chk("acc_pwrite",  bus_if.PWRITE, wr);
         chk("acc_rspv",    bus_if.rsp_valid, 0);
         last = (k == e.n_access - 1);
         bus_if.PREADY = last && !e.err;
         if (last && !e.err && !wr && (RSD == 0)) bus_if.PRDATA = rd;
         else                                      bus_if.PRDATA = 24'($urandom);
         #1;
         chk("acc_req_ready", bus_if.req_ready, last && (wr || (RSD == 0)));
      end
      if (e.rdwait) begin
         @(negedge PCLK);
         chk("rdw_psel",    bus_if.PSELx, 0);
         chk("rdw_penable", bus_if.PENABLE, 0);
         chk("rdw_busy",    bus_if.busy, 1);
         chk("rdw_rspv",    bus_if.rsp_valid, 0);
         chk("rdw_ready",   bus_if.req_ready, 0);
         bus_if.PREADY = 1'b0;
         bus_if.PRDATA = rd;
      end
      @(negedge PCLK);
      chk("rsp_valid",  bus_if.rsp_valid, 1);
      chk("rsp_err",    bus_if.rsp_err, e.err);
      chk("rsp_rdata",  bus_if.rsp_rdata, e.rdata);
      chk("rsp_psel",   bus_if.PSELx, 0);
      chk("rsp_penable", bus_if.PENABLE, 0);
      chk("rsp_busy",   bus_if.busy, 0);
      chk("rsp_ready",  bus_if.req_ready, 1);
      chk("idle_paddr_kept", bus_if.PADDR, a);
      bus_if.PREADY = late_ready;
      bus_if.PRDATA = 24'($urandom);
      @(negedge PCLK);
      chk("rsp_pulse_end", bus_if.rsp_valid, 0);
      chk("rsp_rdata_hold", bus_if.rsp_rdata, e.rdata);
      chk("rsp_err_hold",  bus_if.rsp_err, e.err);
      bus_if.PREADY = 1'b0;
   endtask

   initial begin
      logic [23:0] d1;
      logic [23:0] d2;
      bus_if.req_valid = 1'b0;
      bus_if.req_write = 1'b0;
      bus_if.req_addr  = 4'h0;
      bus_if.req_wdata = 24'h0;
      bus_if.PRDATA    = 24'h0;
      bus_if.PREADY    = 1'b0;
      PRESETn          = 1'b0;
      repeat (2) @(negedge PCLK);
      chk("rst_psel",   bus_if.PSELx, 0);
      chk("rst_penable", bus_if.PENABLE, 0);
      chk("rst_busy",   bus_if.busy, 0);
      chk("rst_rspv",   bus_if.rsp_valid, 0);
      chk("rst_paddr",  bus_if.PADDR, 0);
      chk("rst_pwdata", bus_if.PWDATA, 0);
      chk("rst_rdata",  bus_if.rsp_rdata, 0);
      PRESETn = 1'b1;
      @(negedge PCLK);

      // 1: plain write; 2: delayed read; 3: wait states; 4: timeout with late PREADY
      xfer(1'b1, 4'd2, 24'h0000A5, 0, 24'h0, 1'b0);
      xfer(1'b0, 4'd3, 24'h000000, 0, 24'h000081, 1'b0);
      xfer(1'b1, 4'd4, 24'h123456, 3, 24'h0, 1'b0);
      xfer(1'b0, 4'd5, 24'h000000, 1000, 24'hABCDEF, 1'b1);

      // 5: back-to-back writes with req_valid held
      d1 = 24'($urandom);
      d2 = 24'($urandom);
      bus_if.req_valid = 1'b1;
      bus_if.req_write = 1'b1;
      bus_if.req_addr  = 4'd2;
      bus_if.req_wdata = d1;
      bus_if.PREADY    = 1'b1;
      @(negedge PCLK);
      chk("b2b_setup1_psel", bus_if.PSELx, 1);
      chk("b2b_setup1_paddr", bus_if.PADDR, 2);
      bus_if.req_addr  = 4'd6;
      bus_if.req_wdata = d2;
      @(negedge PCLK);
      chk("b2b_acc1_penable", bus_if.PENABLE, 1);
      chk("b2b_acc1_pwdata", bus_if.PWDATA, d1);
      #1;
      chk("b2b_acc1_ready", bus_if.req_ready, 1);
      @(negedge PCLK);
      bus_if.req_valid = 1'b0;
      chk("b2b_rsp1", bus_if.rsp_valid, 1);
      chk("b2b_setup2_psel", bus_if.PSELx, 1);
      chk("b2b_setup2_penable", bus_if.PENABLE, 0);
      chk("b2b_setup2_paddr", bus_if.PADDR, 6);
      chk("b2b_setup2_pwdata", bus_if.PWDATA, d2);
      @(negedge PCLK);
      chk("b2b_acc2_rspv", bus_if.rsp_valid, 0);
      chk("b2b_acc2_psel", bus_if.PSELx, 1);
      chk("b2b_acc2_penable", bus_if.PENABLE, 1);
      @(negedge PCLK);
      chk("b2b_rsp2", bus_if.rsp_valid, 1);
      chk("b2b_rsp2_err", bus_if.rsp_err, 0);
      chk("b2b_end_psel", bus_if.PSELx, 0);
      bus_if.PREADY = 1'b0;
      @(negedge PCLK);
      chk("b2b_end_rspv", bus_if.rsp_valid, 0);

      // 6: asynchronous reset in the middle of a stalled ACCESS
      bus_if.req_valid = 1'b1;
      bus_if.req_write = 1'b1;
      bus_if.req_addr  = 4'd7;
      bus_if.req_wdata = 24'h5A5A5A;
      @(negedge PCLK);
      bus_if.req_valid = 1'b0;
      @(negedge PCLK);
      chk("pre_rst_penable", bus_if.PENABLE, 1);
      #2;
      PRESETn = 1'b0;
      #1;
      chk("arst_psel",   bus_if.PSELx, 0);
      chk("arst_penable", bus_if.PENABLE, 0);
      chk("arst_paddr",  bus_if.PADDR, 0);
      chk("arst_pwdata", bus_if.PWDATA, 0);
      chk("arst_pwrite", bus_if.PWRITE, 0);
      chk("arst_busy",   bus_if.busy, 0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);
      chk("post_rst_rspv",  bus_if.rsp_valid, 0);
      chk("post_rst_ready", bus_if.req_ready, 1);
      xfer(1'b1, 4'd2, 24'h00C3C3, 0, 24'h0, 1'b0);

      // randomized transfers, including occasional timeouts
      for (int i = 0; i < 24; i++) begin
         xfer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 24'($urandom),
              int'($urandom_range(0, 10)), 24'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Single-outstanding APB requester driving the SAE controller's APB register file (command, transmit, status, receive, ID registers).
- Accepts read/write requests on a valid/ready host interface and runs standard APB SETUP/ACCESS phases.
- Honours PREADY wait states, aborts on a configurable timeout, and returns read data and status as a one-cycle response pulse.

Parameters:
ADDRESSWIDTH, 4, width of req_addr/PADDR; 4 bits so the register map reaches address 9
DATAWIDTH, 24, width of write/read data
TIMEOUT, 16, max ACCESS cycles with PREADY=0 before abort; 0 disables the timeout
RD_SAMPLE_DELAY, 1, 0: capture PRDATA at the completing edge; 1: capture it one PCLK later (responders that register PRDATA in the access phase)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
req_valid  in  1  host request present
req_ready  out  1  master can accept a request this cycle
req_write  in  1  1=write, 0=read
req_addr  in  ADDRESSWIDTH  register address
req_wdata  in  DATAWIDTH  write data
rsp_valid  out  1  one-cycle pulse: transfer finished
rsp_rdata  out  DATAWIDTH  read data; 0 for writes and on error
rsp_err  out  1  valid with rsp_valid; 1 = timeout abort
busy  out  1  high in any state except IDLE
PADDR  out  ADDRESSWIDTH  APB address
PWDATA  out  DATAWIDTH  APB write data
PWRITE  out  1  APB direction
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PRDATA  in  DATAWIDTH  APB read data
PREADY  in  1  APB ready

Behaviour:
- Reset (asynchronous, PRESETn=0, any state, including mid-transfer): state=IDLE and all registered outputs = 0, covering PADDR, PWDATA, PWRITE, PSELx, PENABLE, rsp_valid, rsp_rdata, rsp_err, busy and the timeout counter. An in-flight transfer produces no response.
- All APB outputs and rsp_* are registered. req_ready is combinational:
  - 1 in IDLE;
  - 1 in ACCESS when the transfer completes this cycle (PREADY=1 or timeout), but only for writes or when RD_SAMPLE_DELAY=0;
  - 0 otherwise.
- Request handshake: accepted at a PCLK edge where req_valid & req_ready. req_write, req_addr and req_wdata are latched into PWRITE, PADDR and PWDATA at that edge.
- States:
  - IDLE: PSELx=0, PENABLE=0. On accept -> SETUP.
  - SETUP: PSELx=1, PENABLE=0 for exactly one cycle -> ACCESS. Counter cleared.
  - ACCESS: PSELx=1, PENABLE=1. PADDR, PWDATA and PWRITE are held stable.
    - PREADY=1: transfer completes at this edge, rsp_valid=1 next cycle (except a delayed read, below).
    - PREADY=0: counter increments. When counter reaches TIMEOUT-1 with PREADY still 0 (TIMEOUT>0), abort: rsp_valid=1, rsp_err=1, rsp_rdata=0, PSELx=PENABLE=0, -> IDLE.
    - On completion: with an accept in the same cycle -> SETUP (back-to-back, PSELx stays 1, PENABLE drops); else -> IDLE.
  - RDWAIT (read completion with RD_SAMPLE_DELAY=1): PSELx=0, PENABLE=0 for one cycle. PRDATA is captured at the end of this cycle, rsp_valid=1 the following cycle, -> IDLE.
- Read data rules:
  - RD_SAMPLE_DELAY=0: rsp_rdata = PRDATA sampled at the completing edge.
  - Writes: rsp_rdata=0, rsp_err=0, rsp_valid the cycle after completion.
- Minimum latency from accept edge to rsp_valid high:
  - write: 2 cycles;
  - read: 2 cycles with RD_SAMPLE_DELAY=0, 3 cycles with RD_SAMPLE_DELAY=1.
- rsp_valid is high for exactly 1 cycle per accepted request. rsp_rdata and rsp_err hold until the next response.
- In IDLE, PADDR, PWDATA and PWRITE retain their last values. Only PSELx and PENABLE return to 0.
- req_* changes while req_ready=0 are ignored; requests are never queued.
- A timeout abort is reported even if PREADY rises in the cycle after the abort; that late PREADY is ignored.

Test Plan:
1. Write, PREADY=1: req addr=2, wdata=0x0000A5 accepted at edge 0 -> SETUP cycle 1 (PSELx=1, PENABLE=0, PADDR=2, PWRITE=1), ACCESS cycle 2, rsp_valid=1/rsp_err=0 cycle 3, PSELx=0 cycle 3.
2. Read, RD_SAMPLE_DELAY=1: addr=3, bench drives PRDATA=0x000081 one cycle after completion -> RDWAIT observed, rsp_rdata=0x000081, rsp_valid exactly one cycle, 3 cycles after accept.
3. Wait states: write addr=4, PREADY low for 3 ACCESS cycles then high -> PENABLE high 4 cycles, PADDR/PWDATA stable throughout, single rsp_valid with rsp_err=0.
4. Timeout (TIMEOUT=8): read addr=5, PREADY held 0 -> abort after 8 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSELx/PENABLE=0, req_ready=1 next cycle.
5. Back-to-back writes (addr 2 then 6, req_valid held): second SETUP immediately follows first ACCESS; PSELx never drops; two rsp_valid pulses 2 cycles apart.
6. Reset mid-ACCESS: PRESETn low while PREADY=0 -> all outputs 0 immediately (asynchronous), no rsp_valid; after release, a new write to addr 2 completes normally.
